cp0_core: RTL and testbench
===========================

CP0_CORE -- requirements
Module: cp0_core

Interface
REQ-001 SHALL provide parameter PRID, default 32'h0000_0700, the read-only processor-ID value returned at register 15.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have A1  input  5  mfc0 read register number.
REQ-005 SHALL have A2  input  5  mtc0 write register number.
REQ-006 SHALL have DIn  input  32  mtc0 write data.
REQ-007 SHALL have We  input  1  mtc0 write enable (M stage).
REQ-008 SHALL have PC_M  input  30  word address [31:2] of the M-stage instruction.
REQ-009 SHALL have ExcCode_M  input  5  M-stage exception code [6:2]; 0 = no exception.
REQ-010 SHALL have BD_M  input  1  M-stage instruction sits in a branch delay slot.
REQ-011 SHALL have HWInt  input  6  external interrupt lines [7:2], level-sensitive.
REQ-012 SHALL have EXLClr  input  1  eret in M stage.
REQ-013 SHALL have IntReq  output  1  take exception/interrupt this cycle; flush pipeline.
REQ-014 SHALL have EPC  output  30  exception return word address.
REQ-015 SHALL have DOut  output  32  mfc0 read data.

Function
REQ-016 Registers SHALL be SR(12): IM[15:10], EXL[1], IE[0]; Cause(13): BD[31], IP[15:10], ExcCode[6:2]; EPC(14): [31:2]; PRId(15); all other bits read 0.
REQ-017 DOut SHALL be combinational from A1; unimplemented numbers read 32'h0.
REQ-018 Int SHALL be |(HWInt & SR.IM) & SR.IE & ~SR.EXL; Exc SHALL be (ExcCode_M != 0) & ~SR.EXL; IntReq = Int | Exc, combinational.
REQ-019 Cause.IP SHALL load HWInt every cycle, regardless of other events.
REQ-020 On an edge with IntReq=1: SR.EXL<=1; Cause.ExcCode<=Int ? 5'd0 : ExcCode_M; Cause.BD<=BD_M; EPC<=BD_M ? PC_M-1 : PC_M (30-bit, wraps modulo 2^30).
REQ-021 Interrupt SHALL take priority over a simultaneous synchronous exception.
REQ-022 On an edge with We=1 and IntReq=0: write DIn to register A2 (SR writes IM/EXL/IE only; EPC writes DIn[31:2]); writes to Cause and PRId SHALL be ignored.
REQ-023 On an edge with EXLClr=1 and IntReq=0: SR.EXL<=0; EPC unchanged.
REQ-024 IntReq=1 SHALL suppress a same-cycle mtc0 write and EXLClr.
REQ-025 mtc0 to SR clearing EXL while interrupt pending SHALL raise IntReq from the next cycle.
REQ-026 EPC output SHALL equal the EPC register (no bypass of same-cycle writes).

Reset
REQ-027 On reset low, asynchronously: SR, Cause, EPC SHALL become 0; IntReq therefore 0; DOut reflects zeroed state.
REQ-028 Reset asserted mid-handling SHALL discard the pending EXL/EPC update; first post-reset edge behaves as from idle.

Configuration
REQ-029 Macro CP0_EXC_CNT_EN SHALL, when defined, add register 16: 32-bit count of edges with IntReq=1, wraps 32'hFFFF_FFFF->0, reset 0, mtc0-writable when IntReq=0; IntReq edge increments and overrides write.
REQ-030 Without CP0_EXC_CNT_EN, register 16 SHALL read 0 and writes SHALL be ignored; no counter logic.

Verification
REQ-031 SR<=32'h0000_0401 via mtc0, HWInt=6'b000001 -> IntReq=1 same cycle; next edge Cause.ExcCode=0, EXL=1, IntReq=0.
REQ-032 ExcCode_M=5'd12, BD_M=1, PC_M=30'h0000_0C01, EXL=0 -> EPC=30'h0000_0C00, Cause=32'h8000_0030.
REQ-033 ExcCode_M=5'd10 and enabled HWInt together -> Cause.ExcCode=0 (interrupt wins); same-cycle mtc0 EPC write dropped.
REQ-034 EXL=1, EXLClr=1 with ExcCode_M=5'd4 -> IntReq=0 that cycle; EXL=0 after edge; IntReq=1 following cycle if ExcCode_M still 4.
REQ-035 Reset low mid-cycle after IntReq -> SR/Cause/EPC read 0 immediately; A1=15 returns PRID.
REQ-036 With CP0_EXC_CNT_EN, mtc0 reg16<=32'hFFFF_FFFF then one exception -> reg16 reads 0; without macro reads 0 always.

Source files
------------

// File: rtl/cp0_core.sv
// Coprocessor-0 for a 5-stage MIPS pipeline: SR/Cause/EPC/PRId, interrupt and exception entry, eret.
// Latency: mfc0 read data (DOut) and IntReq are combinational; register updates land on the next rising clk edge.
// Backpressure: none; IntReq is a flush request that the pipeline must honour in the same cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   A1 -> DOut      : mfc0 read port (register number -> 32-bit data)
//   A2, DIn, We     : mtc0 write port (M stage)
//   PC_M, ExcCode_M, BD_M : M-stage instruction context captured on exception entry
//   HWInt           : level-sensitive external interrupt lines [7:2]
//   EXLClr          : eret in M stage
//   IntReq          : take exception/interrupt this cycle
//   EPC             : exception return word address
// Optional feature: define CP0_EXC_CNT_EN to add register 16, a count of exception/interrupt entries.
module cp0_core #(
    parameter logic [31:0] PRID = 32'h0000_0700
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [29:0] PC_M,
    input  logic [4:0]  ExcCode_M,
    input  logic        BD_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;
`ifdef CP0_EXC_CNT_EN
    localparam logic [4:0] REG_CNT   = 5'd16;
`endif

    // Status register fields
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    // Cause register fields
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    // Exception PC (word address)
    logic [29:0] epc_r;

    logic        int_hit;
    logic        exc_hit;
    logic        wr_ok;

    // Interrupts and exceptions are both masked while already in the handler (EXL=1).
    assign int_hit = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_hit = (ExcCode_M != 5'd0) & ~sr_exl;
    assign IntReq  = int_hit | exc_hit;

    // mtc0 and eret only take effect when no exception entry is happening this edge.
    assign wr_ok   = ~IntReq;

    assign EPC     = epc_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc_r     <= 30'd0;
        end else begin
            // Pending-interrupt bits mirror the lines unconditionally.
            cause_ip <= HWInt;
            if (IntReq) begin
                sr_exl    <= 1'b1;
                // Interrupt wins over a simultaneous synchronous exception.
                cause_exc <= int_hit ? 5'd0 : ExcCode_M;
                cause_bd  <= BD_M;
                // A delay-slot instruction restarts at its branch, one word earlier.
                epc_r     <= BD_M ? (PC_M - 30'd1) : PC_M;
            end else begin
                if (We && (A2 == REG_SR)) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (We && (A2 == REG_EPC)) begin
                    epc_r <= DIn[31:2];
                end
                // eret applied after the mtc0 so it always leaves EXL cleared.
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

`ifdef CP0_EXC_CNT_EN
    logic [31:0] exc_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_cnt <= 32'd0;
        end else if (IntReq) begin
            exc_cnt <= exc_cnt + 32'd1;
        end else if (wr_ok && We && (A2 == REG_CNT)) begin
            exc_cnt <= DIn;
        end
    end
`endif

    always_comb begin
        DOut = 32'h0;
        case (A1)
            REG_SR:    DOut = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
            REG_CAUSE: DOut = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'h0};
            REG_EPC:   DOut = {epc_r, 2'b00};
            REG_PRID:  DOut = PRID;
`ifdef CP0_EXC_CNT_EN
            REG_CNT:   DOut = exc_cnt;
`endif
            default:   DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_core.sv
// Directed bench for cp0_core: hand-computed register values after each step.
// Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
// Register 16 expectations depend on whether CP0_EXC_CNT_EN is defined.
module tb_cp0_core;

    localparam logic [31:0] PRID = 32'h0000_0700;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [29:0] PC_M;
    logic [4:0]  ExcCode_M;
    logic        BD_M;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_core #(.PRID(PRID)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .We        (We),
        .PC_M      (PC_M),
        .ExcCode_M (ExcCode_M),
        .BD_M      (BD_M),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        A1 = addr;
        #1;
        chk(tag, DOut, exp);
    endtask

    initial begin
        reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; We = 1'b0;
        PC_M = 30'h0; ExcCode_M = 5'd0; BD_M = 1'b0; HWInt = 6'd0; EXLClr = 1'b0;
        #2;
        // Reset state
        chk("rst_intreq", {31'h0, IntReq}, 32'h0);
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc_rd", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, PRID);
        chk("rst_epc", {2'b0, EPC}, 32'h0);
        repeat (2) tick();
        reset = 1'b1;

        // mtc0 SR: IM[10], IE
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        We = 1'b0;
        rd("sr_write", 5'd12, 32'h0000_0401);
        chk("sr_write_noint", {31'h0, IntReq}, 32'h0);

        // Enabled interrupt line -> IntReq in the same cycle
        HWInt = 6'b000001; PC_M = 30'h100;
        #1;
        chk("int_same_cycle", {31'h0, IntReq}, 32'h1);
        tick();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr_exl", 5'd12, 32'h0000_0403);
        chk("int_exl_masks", {31'h0, IntReq}, 32'h0);
        chk("int_epc", {2'b0, EPC}, 32'h0000_0100);

        // mtc0 SR clearing EXL while interrupt pending -> IntReq from next cycle
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        #1;
        chk("exlclr_wr_wait", {31'h0, IntReq}, 32'h0);
        tick();
        We = 1'b0;
        #1;
        chk("exlclr_wr_int", {31'h0, IntReq}, 32'h1);

        // Interrupt and exception together; same-cycle mtc0 EPC dropped
        ExcCode_M = 5'd10; We = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEE0; PC_M = 30'h200;
        tick();
        We = 1'b0; ExcCode_M = 5'd0;
        rd("prio_cause", 5'd13, 32'h0000_0400);
        chk("prio_epc", {2'b0, EPC}, 32'h0000_0200);
        rd("prio_sr", 5'd12, 32'h0000_0403);

        // eret suppressed-exception window
        HWInt = 6'd0; ExcCode_M = 5'd4; EXLClr = 1'b1;
        #1;
        chk("eret_no_req", {31'h0, IntReq}, 32'h0);
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("eret_epc_kept", {2'b0, EPC}, 32'h0000_0200);
        chk("eret_then_exc", {31'h0, IntReq}, 32'h1);

        // Exception in a delay slot
        ExcCode_M = 5'd12; BD_M = 1'b1; PC_M = 30'h0000_0C01;
        tick();
        ExcCode_M = 5'd0; BD_M = 1'b0;
        #1;
        chk("bd_epc", {2'b0, EPC}, 32'h0000_0C00);
        rd("bd_cause", 5'd13, 32'h8000_0030);
        rd("bd_epc_rd", 5'd14, 32'h0000_3000);
        chk("bd_noreq", {31'h0, IntReq}, 32'h0);

        // EPC wrap on delay slot at address 0
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; ExcCode_M = 5'd8; BD_M = 1'b1; PC_M = 30'h0;
        #1;
        chk("wrap_req", {31'h0, IntReq}, 32'h1);
        tick();
        ExcCode_M = 5'd0; BD_M = 1'b0;
        #1;
        chk("wrap_epc", {2'b0, EPC}, 32'h3FFF_FFFF);
        rd("wrap_cause", 5'd13, 32'h8000_0020);

        // Writes to read-only / unimplemented registers, EPC write (no bypass)
        We = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 5'd15;
        tick();
        A2 = 5'd14; DIn = 32'h1234_567B;
        #1;
        chk("epc_no_bypass", {2'b0, EPC}, 32'h3FFF_FFFF);
        tick();
        A2 = 5'd16; DIn = 32'hFFFF_FFFF;
        tick();
        We = 1'b0;
        rd("cause_ro", 5'd13, 32'h8000_0020);
        rd("prid_ro", 5'd15, PRID);
        rd("epc_wr_rd", 5'd14, 32'h1234_5678);
        chk("epc_wr", {2'b0, EPC}, 32'h048D_159E);
`ifdef CP0_EXC_CNT_EN
        rd("cnt_wr", 5'd16, 32'hFFFF_FFFF);
`else
        rd("cnt_absent", 5'd16, 32'h0);
`endif
        rd("unimpl", 5'd3, 32'h0);
        rd("sr_keep", 5'd12, 32'h0000_0403);

        // One exception after reg16 <= FFFF_FFFF -> wraps to 0 (or absent: 0)
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; ExcCode_M = 5'd4;
        #1;
        chk("cnt_exc_req", {31'h0, IntReq}, 32'h1);
        tick();
        ExcCode_M = 5'd0;
        rd("cnt_wrap", 5'd16, 32'h0);

        // Reset asserted mid-cycle while IntReq is high
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; ExcCode_M = 5'd4; PC_M = 30'h55;
        #1;
        chk("mid_req", {31'h1 & 31'h0, IntReq}, 32'h1);
        #1;
        reset = 1'b0; ExcCode_M = 5'd0;
        #1;
        chk("mid_rst_req", {31'h0, IntReq}, 32'h0);
        chk("mid_rst_epc", {2'b0, EPC}, 32'h0);
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        rd("mid_rst_prid", 5'd15, PRID);
        tick();
        reset = 1'b1;
        tick();
        rd("post_rst_sr", 5'd12, 32'h0);
        rd("post_rst_cause", 5'd13, 32'h0);
        chk("post_rst_epc", {2'b0, EPC}, 32'h0);
        chk("post_rst_req", {31'h0, IntReq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
